// File: rtl/uart_pkg.sv
// Shared UART definitions: line-state encoding, parity modes and a parity helper.
// Intended for use by both the transmitter and a future receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    // Widest legal data word; narrower words are zero-extended before the parity reduction.
    localparam int unsigned MAX_W = 9;

    function automatic logic parity_bit(input logic [MAX_W-1:0] word, input int unsigned mode);
        logic ones_odd;
        ones_odd = ^word;
        return (mode == PAR_ODD) ? ~ones_odd : ones_odd;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register behind valid/ready, LSB-first framing with
// optional parity and one or two stop bits, advancing one bit per cke strobe.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned W      = 8,
    parameter int unsigned PARITY = 0,
    parameter int unsigned STOP   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cke,
    input  logic [W-1:0] data,
    input  logic         valid,
    output logic         ready,
    output logic         tx,
    output logic         busy
);

    localparam int unsigned IdxW = $clog2(W);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(W - 1);
    localparam logic LastStop = (STOP == 2);

    if (W < 5 || W > 9) begin : g_bad_w
        $error("uart_tx: W must be in 5..9");
    end
    if (PARITY > PAR_EVEN) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP < 1 || STOP > 2) begin : g_bad_stop
        $error("uart_tx: STOP must be 1 or 2");
    end

    uart_state_t     state_q, state_d;
    logic [W-1:0]    hold_q, hold_d;
    logic            hold_full_q, hold_full_d;
    logic [W-1:0]    shift_q, shift_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            stop_q, stop_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            accept;
    logic            load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            idx_q       <= '0;
            stop_q      <= 1'b0;
            par_q       <= 1'b0;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            stop_q      <= stop_d;
            par_q       <= par_d;
            tx_q        <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cke) begin
            unique case (state_q)
                StIdle: begin
                    if (hold_full_q) state_d = StStart;
                end
                StStart: state_d = StData;
                StData: begin
                    if (idx_q == LastIdx) begin
                        state_d = (PARITY != PAR_NONE) ? StParity : StStop;
                    end
                end
                StParity: state_d = StStop;
                StStop: begin
                    if (stop_q == LastStop) begin
                        state_d = hold_full_q ? StStart : StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // StStart is only ever entered from a load, so a fresh entry marks the load cycle.
    assign load   = (state_d == StStart) && (state_q != StStart);
    assign accept = valid && !hold_full_q;

    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        stop_d      = stop_q;
        par_d       = par_q;
        tx_d        = tx_q;

        if (accept) begin
            hold_d      = data;
            hold_full_d = 1'b1;
        end else if (load) begin
            hold_full_d = 1'b0;
        end

        if (load) begin
            shift_d = hold_q;
            par_d   = parity_bit(MAX_W'(hold_q), PARITY);
            tx_d    = 1'b0;
        end else if (cke) begin
            unique case (state_q)
                StStart: begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    idx_d   = '0;
                end
                StData: begin
                    if (idx_q != LastIdx) begin
                        idx_d   = idx_q + 1'b1;
                        tx_d    = shift_q[0];
                        shift_d = shift_q >> 1;
                    end else if (PARITY != PAR_NONE) begin
                        tx_d = par_q;
                    end else begin
                        tx_d   = 1'b1;
                        stop_d = 1'b0;
                    end
                end
                StParity: begin
                    tx_d   = 1'b1;
                    stop_d = 1'b0;
                end
                StStop: begin
                    if (stop_q != LastStop) begin
                        stop_d = 1'b1;
                    end else begin
                        tx_d = 1'b1;
                    end
                end
                default: tx_d = 1'b1;
            endcase
        end
    end

    assign tx    = tx_q;
    assign ready = !hold_full_q;
    assign busy  = (state_q != StIdle) || hold_full_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: framing, parity variants, back-to-back, stall, reset, cke high.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic       cke;
    logic [7:0] data;
    logic       valid;
    logic       valid_p;
    logic       ready, tx, busy;
    logic       ready_e, tx_e, busy_e;
    logic       ready_o, tx_o, busy_o;

    int checks = 0;
    int errors = 0;
    int cke_mode = 0;  // 0: every 4th cycle, 1: tied high, 2: off
    int cke_cnt = 0;

    uart_tx #(.W(8), .PARITY(0), .STOP(1)) u_dut (
        .clk(clk), .rst(rst), .cke(cke), .data(data), .valid(valid),
        .ready(ready), .tx(tx), .busy(busy)
    );

    uart_tx #(.W(8), .PARITY(2), .STOP(2)) u_even (
        .clk(clk), .rst(rst), .cke(cke), .data(data), .valid(valid_p),
        .ready(ready_e), .tx(tx_e), .busy(busy_e)
    );

    uart_tx #(.W(8), .PARITY(1), .STOP(1)) u_odd (
        .clk(clk), .rst(rst), .cke(cke), .data(data), .valid(valid_p),
        .ready(ready_o), .tx(tx_o), .busy(busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cke = 1'b0;
        forever begin
            @(negedge clk);
            cke_cnt = (cke_cnt + 1) % 4;
            case (cke_mode)
                0:       cke = (cke_cnt == 0);
                1:       cke = 1'b1;
                default: cke = 1'b0;
            endcase
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic sel_tx(input int sel);
        case (sel)
            1:       return tx_e;
            2:       return tx_o;
            default: return tx;
        endcase
    endfunction

    task automatic wait_start(input int sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sel_tx(sel) === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Sample every cycle of every bit: checks both value and exact bit duration.
    task automatic check_seq(input int sel, input logic [31:0] seq, input int n, input int t,
                             input string tag);
        bit ok;
        wait_start(sel, ok);
        chk_bit({tag, "_start"}, ok, 1'b1);
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                for (int j = 0; j < t; j++) begin
                    chk_bit($sformatf("%s_bit%0d_cyc%0d", tag, i, j), sel_tx(sel), seq[i]);
                    @(negedge clk);
                end
            end
        end
    endtask

    // Leaves valid high on return so consecutive offers form a held-valid stream.
    task automatic offer(input logic [7:0] w, input string tag);
        bit waited;
        bit ok;
        waited = 1'b0;
        ok     = 1'b0;
        data   = w;
        valid  = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            waited = 1'b1;
            @(negedge clk);
        end
        chk_bit({tag, "_ready_seen"}, ok, 1'b1);
        if (waited) chk_bit({tag, "_ready_rise_at_load_tx"}, tx, 1'b0);
        @(negedge clk);
        chk_bit({tag, "_ready_low_after_accept"}, ready, 1'b0);
    endtask

    initial begin
        bit ok;
        int lows;
        rst     = 1'b1;
        data    = 8'h00;
        valid   = 1'b0;
        valid_p = 1'b0;
        repeat (3) @(negedge clk);
        chk_bit("reset_tx", tx, 1'b1);
        chk_bit("reset_ready", ready, 1'b1);
        chk_bit("reset_busy", busy, 1'b0);
        chk_bit("reset_tx_even", tx_e, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // Parity variants, both DUTs fed 0x07 together
        data    = 8'h07;
        valid_p = 1'b1;
        @(negedge clk);
        valid_p = 1'b0;
        fork
            check_seq(1, {20'd0, 2'b11, 1'b1, 8'h07, 1'b0}, 12, 4, "even");
            check_seq(2, {21'd0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 4, "odd");
        join
        chk_bit("even_busy_end", busy_e, 1'b0);
        chk_bit("odd_busy_end", busy_o, 1'b0);

        // Basic frame 0xA5
        offer(8'hA5, "basic");
        valid = 1'b0;
        chk_bit("basic_busy", busy, 1'b1);
        check_seq(0, {22'd0, 1'b1, 8'hA5, 1'b0}, 10, 4, "basic");
        chk_bit("basic_busy_end", busy, 1'b0);

        // Back-to-back with valid held
        fork
            begin
                offer(8'h00, "b2b0");
                offer(8'hFF, "b2b1");
                valid = 1'b0;
            end
            check_seq(0, {12'd0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0}, 20, 4, "b2b");
        join
        chk_bit("b2b_busy_end", busy, 1'b0);

        // Handshake stall: cke off, register full, 0x3C offered meanwhile
        cke_mode = 2;
        repeat (2) @(negedge clk);
        offer(8'h11, "stall0");
        data = 8'h3C;
        repeat (8) @(negedge clk);
        chk_bit("stall_ready", ready, 1'b0);
        chk_bit("stall_tx", tx, 1'b1);
        chk_bit("stall_busy", busy, 1'b1);
        fork
            begin
                cke_mode = 0;
                offer(8'h3C, "stall1");
                valid = 1'b0;
            end
            check_seq(0, {12'd0, 1'b1, 8'h3C, 1'b0, 1'b1, 8'h11, 1'b0}, 20, 4, "stall");
        join
        lows = 0;
        repeat (48) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk_int("stall_sent_once", lows, 0);
        chk_bit("stall_busy_end", busy, 1'b0);
        chk_bit("stall_ready_end", ready, 1'b1);

        // Reset during data bit 3 of 0x96
        offer(8'h96, "rst0");
        valid = 1'b0;
        wait_start(0, ok);
        chk_bit("rst_frame_start", ok, 1'b1);
        repeat (16) @(negedge clk);
        chk_bit("rst_pre_d3", tx, 1'b0);
        chk_bit("rst_pre_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk_bit("rst_mid_tx", tx, 1'b1);
        chk_bit("rst_mid_ready", ready, 1'b1);
        chk_bit("rst_mid_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        offer(8'hC3, "post_rst");
        valid = 1'b0;
        check_seq(0, {22'd0, 1'b1, 8'hC3, 1'b0}, 10, 4, "post_rst");
        chk_bit("post_rst_busy_end", busy, 1'b0);

        // cke tied high: one bit per clock
        cke_mode = 1;
        repeat (2) @(negedge clk);
        offer(8'h5A, "hi");
        valid = 1'b0;
        check_seq(0, {22'd0, 1'b1, 8'h5A, 1'b0}, 10, 1, "hi");
        chk_bit("hi_busy_end", busy, 1'b0);
        chk_bit("hi_tx_idle", tx, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
